// File: rtl/ibex_rf_backing_store.sv
// Architectural register backing store with a write buffer and an in-order miss-fill responder.
// Define IBEX_RF_BS_FWD_EN to forward buffered writes into read launches instead of stalling them.
module ibex_rf_backing_store #(
   parameter int unsigned DataWidth   = 32,
   parameter int unsigned AddrWidth   = 5,
   parameter int unsigned ReadLatency = 2,
   parameter int unsigned WbDepth     = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic                 req_tag_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [AddrWidth-1:0] rsp_addr_o,
   output logic                 rsp_tag_o,
   output logic [DataWidth-1:0] rsp_data_o,
   input  logic                 wr_valid_i,
   output logic                 wr_ready_o,
   input  logic [AddrWidth-1:0] wr_addr_i,
   input  logic [DataWidth-1:0] wr_data_i,
   output logic                 busy_o
);
   // state | meaning
   // IDLE  | no read in flight
   // WAIT  | storage read in progress, latency counter running down
   // RESP  | response presented and held until rsp_ready_i
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   localparam int unsigned NumRegs = 2 ** AddrWidth;
   localparam logic [1:0]  LoadCnt = 2'(ReadLatency - 1);
   localparam logic [2:0]  WbFull  = 3'(WbDepth);

   state_e state_q, state_d;
   logic [1:0] cnt_q, cnt_d;

   logic [NumRegs-1:0][DataWidth-1:0] rf_q;

   logic [1:0][AddrWidth-1:0] rq_addr_q;
   logic [1:0]                rq_tag_q;
   logic                      rq_wptr_q, rq_rptr_q;
   logic [1:0]                rq_cnt_q;

   logic [WbDepth-1:0][AddrWidth-1:0] wb_addr_q;
   logic [WbDepth-1:0][DataWidth-1:0] wb_data_q;
   logic [2:0]                        wb_cnt_q;

   logic                 req_push, wb_push, wr_fire;
   logic                 wb_full, wb_empty;
   logic                 can_take, launch, drain, hazard_ok, fwd_hit;
   logic [2:0]           wb_wr_idx;
   logic [AddrWidth-1:0] head_addr;
   logic                 head_tag;
   logic [DataWidth-1:0] launch_data;

   assign wb_full     = (wb_cnt_q == WbFull);
   assign wb_empty    = (wb_cnt_q == 3'd0);
   assign req_ready_o = (rq_cnt_q != 2'd2);
   assign wr_ready_o  = !wb_full;
   assign req_push    = req_valid_i && req_ready_o;
   assign wr_fire     = wr_valid_i && wr_ready_o;
   assign wb_push     = wr_fire && (wr_addr_i != '0);
   assign head_addr   = rq_addr_q[rq_rptr_q];
   assign head_tag    = rq_tag_q[rq_rptr_q];

   always_comb begin
      fwd_hit = 1'b0;
      for (int i = 0; i < WbDepth; i++) begin
         if ((3'(i) < wb_cnt_q) && (wb_addr_q[i] == head_addr)) begin
            fwd_hit = 1'b1;
         end
      end
   end

`ifdef IBEX_RF_BS_FWD_EN
   logic [DataWidth-1:0] fwd_data;

   // Later entries are younger, so the last match wins.
   always_comb begin
      fwd_data = '0;
      for (int i = 0; i < WbDepth; i++) begin
         if ((3'(i) < wb_cnt_q) && (wb_addr_q[i] == head_addr)) begin
            fwd_data = wb_data_q[i];
         end
      end
   end

   assign hazard_ok   = 1'b1;
   assign launch_data = (head_addr == '0) ? '0 : (fwd_hit ? fwd_data : rf_q[head_addr]);
`else
   assign hazard_ok   = !fwd_hit;
   assign launch_data = (head_addr == '0) ? '0 : rf_q[head_addr];
`endif

   // The array is single-ported: a full buffer always wins, otherwise reads go first.
   assign can_take = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready_i);
   assign launch   = (rq_cnt_q != 2'd0) && can_take && !wb_full && hazard_ok;
   assign drain    = wb_full || (!launch && !wb_empty);

   assign wb_wr_idx = drain ? (wb_cnt_q - 3'd1) : wb_cnt_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (launch) begin
         cnt_d   = LoadCnt;
         state_d = (LoadCnt == 2'd0) ? S_RESP : S_WAIT;
      end else begin
         case (state_q)
            S_WAIT: begin
               cnt_d = cnt_q - 2'd1;
               if (cnt_d == 2'd0) begin
                  state_d = S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready_i) begin
                  state_d = S_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         cnt_q      <= 2'd0;
         rsp_addr_o <= '0;
         rsp_tag_o  <= 1'b0;
         rsp_data_o <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (launch) begin
            rsp_addr_o <= head_addr;
            rsp_tag_o  <= head_tag;
            rsp_data_o <= launch_data;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rq_addr_q <= '0;
         rq_tag_q  <= '0;
         rq_wptr_q <= 1'b0;
         rq_rptr_q <= 1'b0;
         rq_cnt_q  <= 2'd0;
      end else begin
         if (req_push) begin
            rq_addr_q[rq_wptr_q] <= req_addr_i;
            rq_tag_q[rq_wptr_q]  <= req_tag_i;
            rq_wptr_q            <= !rq_wptr_q;
         end
         if (launch) begin
            rq_rptr_q <= !rq_rptr_q;
         end
         rq_cnt_q <= rq_cnt_q + {1'b0, req_push} - {1'b0, launch};
      end
   end

   // Write buffer is a shift queue with the head at index 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wb_addr_q <= '0;
         wb_data_q <= '0;
         wb_cnt_q  <= 3'd0;
         rf_q      <= '0;
      end else begin
         if (drain) begin
            rf_q[wb_addr_q[0]] <= wb_data_q[0];
            for (int i = 0; i < WbDepth - 1; i++) begin
               wb_addr_q[i] <= wb_addr_q[i+1];
               wb_data_q[i] <= wb_data_q[i+1];
            end
         end
         for (int i = 0; i < WbDepth; i++) begin
            if (wb_push && (3'(i) == wb_wr_idx)) begin
               wb_addr_q[i] <= wr_addr_i;
               wb_data_q[i] <= wr_data_i;
            end
         end
         wb_cnt_q <= wb_cnt_q + {2'b0, wb_push} - {2'b0, drain};
      end
   end

   assign rsp_valid_o = (state_q == S_RESP);
   assign busy_o      = (rq_cnt_q != 2'd0) || (state_q != S_IDLE) || !wb_empty;

endmodule

// File: tb/tb_ibex_rf_backing_store.sv
// Scoreboard bench for ibex_rf_backing_store: directed scenarios plus randomized traffic
// checked against a plain register-array model.
module tb_ibex_rf_backing_store;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int RL = 2;
   localparam int WB = 2;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic [AW-1:0] req_addr_i = '0;
   logic          req_tag_i = 1'b0;
   logic          rsp_valid_o;
   logic          rsp_ready_i = 1'b1;
   logic [AW-1:0] rsp_addr_o;
   logic          rsp_tag_o;
   logic [DW-1:0] rsp_data_o;
   logic          wr_valid_i = 1'b0;
   logic          wr_ready_o;
   logic [AW-1:0] wr_addr_i = '0;
   logic [DW-1:0] wr_data_i = '0;
   logic          busy_o;

   always #5 clk_i = ~clk_i;

   ibex_rf_backing_store #(
      .DataWidth(DW), .AddrWidth(AW), .ReadLatency(RL), .WbDepth(WB)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_tag_i(req_tag_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_addr_o(rsp_addr_o), .rsp_tag_o(rsp_tag_o), .rsp_data_o(rsp_data_o),
      .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
      .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
      .busy_o(busy_o)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          tag;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb_q[$];
   logic [DW-1:0] ref_mem [2**AW];
   int            n_checks = 0;
   int            n_errors = 0;

   // Model: a read returns every write handshaken up to and including its own acceptance cycle.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         foreach (ref_mem[i]) ref_mem[i] = '0;
         sb_q.delete();
      end else begin
         if (wr_valid_i && wr_ready_o && (wr_addr_i != '0)) ref_mem[wr_addr_i] = wr_data_i;
         if (req_valid_i && req_ready_o) sb_q.push_back({req_addr_i, req_tag_i, ref_mem[req_addr_i]});
      end
   end

   exp_t          exp_m;
   logic          hold_q = 1'b0;
   logic [AW-1:0] hold_addr;
   logic          hold_tag;
   logic [DW-1:0] hold_data;

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         hold_q = 1'b0;
      end else begin
         if (hold_q) begin
            n_checks++;
            if (!rsp_valid_o || rsp_addr_o != hold_addr || rsp_tag_o != hold_tag || rsp_data_o != hold_data) begin
               n_errors++;
               $display("FAIL rsp_hold: got valid=%0b addr=%0d tag=%0b data=%h, want valid=1 addr=%0d tag=%0b data=%h",
                        rsp_valid_o, rsp_addr_o, rsp_tag_o, rsp_data_o, hold_addr, hold_tag, hold_data);
            end
         end
         if (rsp_valid_o && rsp_ready_i) begin
            n_checks++;
            if (sb_q.size() == 0) begin
               n_errors++;
               $display("FAIL rsp_unexpected: got addr=%0d tag=%0b data=%h, want no response",
                        rsp_addr_o, rsp_tag_o, rsp_data_o);
            end else begin
               exp_m = sb_q.pop_front();
               if (rsp_addr_o != exp_m.addr || rsp_tag_o != exp_m.tag || rsp_data_o != exp_m.data) begin
                  n_errors++;
                  $display("FAIL rsp_data: got addr=%0d tag=%0b data=%h, want addr=%0d tag=%0b data=%h",
                           rsp_addr_o, rsp_tag_o, rsp_data_o, exp_m.addr, exp_m.tag, exp_m.data);
               end
            end
         end
         hold_q    = rsp_valid_o && !rsp_ready_i;
         hold_addr = rsp_addr_o;
         hold_tag  = rsp_tag_o;
         hold_data = rsp_data_o;
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic t);
      bit acc = 1'b0;
      req_valid_i = 1'b1;
      req_addr_i  = a;
      req_tag_i   = t;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk_i);
         acc = req_ready_o;
         step();
      end
      req_valid_i = 1'b0;
      chk("req_accept", 64'(acc), 64'd1);
   endtask

   int wr_low_cnt = 0;

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit acc = 1'b0;
      wr_valid_i = 1'b1;
      wr_addr_i  = a;
      wr_data_i  = d;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk_i);
         acc = wr_ready_o;
         if (!wr_ready_o) wr_low_cnt++;
         step();
      end
      wr_valid_i = 1'b0;
      chk("wr_accept", 64'(acc), 64'd1);
   endtask

   task automatic wait_idle(input int max_cyc);
      bit done = 1'b0;
      for (int k = 0; k < max_cyc && !done; k++) begin
         @(negedge clk_i);
         if (!busy_o && sb_q.size() == 0) done = 1'b1;
      end
      chk("drain_idle", 64'(done), 64'd1);
      step();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
      chk({tag, "_wr_ready"},  64'(wr_ready_o),  64'd1);
      chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
      chk({tag, "_rsp_addr"},  64'(rsp_addr_o),  64'd0);
      chk({tag, "_rsp_tag"},   64'(rsp_tag_o),   64'd0);
      chk({tag, "_rsp_data"},  64'(rsp_data_o),  64'd0);
      chk({tag, "_busy"},      64'(busy_o),      64'd0);
   endtask

   function automatic bit wr_addr_ok(input logic [AW-1:0] a);
      if (req_valid_i && req_addr_i == a) return 1'b0;
      foreach (sb_q[i]) if (sb_q[i].addr == a) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [AW-1:0] pick_addr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 2**AW - 1));
      return AW'($urandom_range(0, 7));
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int            lat, t1, t2, nseen;
      bit            found, req_fire, wr_fire;
      logic [AW-1:0] a;

      repeat (3) @(negedge clk_i);
      chk_reset_outputs("rst");
      step();
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("post_rst_req_ready", 64'(req_ready_o), 64'd1);
      step();

      // Basic fill latency
      do_read(5'd5, 1'b1);
      lat = 0;
      found = 1'b0;
      for (int i = 1; i <= 10 && !found; i++) begin
         @(negedge clk_i);
         if (rsp_valid_o) begin
            found = 1'b1;
            lat = i;
         end
      end
      chk("fill_latency", 64'(lat), 64'(RL + 1));
      wait_idle(50);

      // Forwarding hit: read right behind a write to the same register
      do_write(5'd7, 32'hDEADBEEF);
      do_read(5'd7, 1'b0);
      wait_idle(50);

      // Back-to-back throughput
      do_write(5'd1, 32'h1111_0001);
      do_write(5'd2, 32'h2222_0002);
      wait_idle(50);
      do_read(5'd1, 1'b0);
      do_read(5'd2, 1'b1);
      t1 = -1;
      t2 = -1;
      nseen = 0;
      for (int i = 0; i < 20 && nseen < 2; i++) begin
         @(negedge clk_i);
         if (rsp_valid_o && rsp_ready_i) begin
            if (nseen == 0) t1 = i;
            else t2 = i;
            nseen++;
         end
      end
      chk("b2b_gap", 64'(t2 - t1), 64'(RL));
      wait_idle(50);

      // Back-pressure
      do_write(5'd3, 32'hA5A5_0003);
      do_write(5'd4, 32'h5A5A_0004);
      wait_idle(50);
      rsp_ready_i = 1'b0;
      do_read(5'd3, 1'b0);
      do_read(5'd4, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk_i);
         found = rsp_valid_o;
      end
      chk("bp_rsp_valid", 64'(found), 64'd1);
      repeat (5) @(negedge clk_i);
      chk("bp_req_ready", 64'(req_ready_o), 64'd1);
      chk("bp_rsp_addr", 64'(rsp_addr_o), 64'd3);
      step();
      rsp_ready_i = 1'b1;
      wait_idle(50);

      // Write buffer full with a read pending
      wr_low_cnt  = 0;
      req_valid_i = 1'b1;
      req_addr_i  = 5'd10;
      req_tag_i   = 1'b0;
      do_write(5'd11, 32'h0B0B_0011);
      req_valid_i = 1'b0;
      do_write(5'd12, 32'h0C0C_0012);
      do_write(5'd13, 32'h0D0D_0013);
      chk("wb_full_seen", 64'(wr_low_cnt > 0), 64'd1);
      do_read(5'd11, 1'b0);
      do_read(5'd12, 1'b1);
      do_read(5'd13, 1'b0);
      wait_idle(50);

      // Address 0
      do_write(5'd0, 32'h0000_1234);
      @(negedge clk_i);
      chk("x0_busy", 64'(busy_o), 64'd0);
      step();
      do_read(5'd0, 1'b1);
      wait_idle(50);

      // Reset during WAIT
      do_write(5'd5, 32'h5555_5555);
      wait_idle(50);
      do_read(5'd5, 1'b0);
      step();
      rst_ni = 1'b0;
      @(negedge clk_i);
      chk_reset_outputs("mid_rst");
      step();
      rst_ni = 1'b1;
      step();
      do_read(5'd5, 1'b1);
      wait_idle(50);

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk_i);
         req_fire = req_valid_i && req_ready_o;
         wr_fire  = wr_valid_i && wr_ready_o;
         step();
         if (wr_fire) wr_valid_i = 1'b0;
         if (req_fire) req_valid_i = 1'b0;
         rsp_ready_i = ($urandom_range(0, 9) < 7);
         if (!wr_valid_i && $urandom_range(0, 2) == 0) begin
            a = pick_addr();
            if (wr_addr_ok(a)) begin
               wr_valid_i = 1'b1;
               wr_addr_i  = a;
               wr_data_i  = $urandom;
            end
         end
         if (!req_valid_i && $urandom_range(0, 1) == 0) begin
            a = pick_addr();
            if (!(wr_valid_i && wr_addr_i == a)) begin
               req_valid_i = 1'b1;
               req_addr_i  = a;
               req_tag_i   = 1'($urandom_range(0, 1));
            end
         end
      end
      @(negedge clk_i);
      req_fire = req_valid_i && req_ready_o;
      wr_fire  = wr_valid_i && wr_ready_o;
      step();
      if (wr_fire) wr_valid_i = 1'b0;
      if (req_fire) req_valid_i = 1'b0;
      for (int k = 0; k < 50 && (wr_valid_i || req_valid_i); k++) begin
         @(negedge clk_i);
         req_fire = req_valid_i && req_ready_o;
         wr_fire  = wr_valid_i && wr_ready_o;
         rsp_ready_i = 1'b1;
         step();
         if (wr_fire) wr_valid_i = 1'b0;
         if (req_fire) req_valid_i = 1'b0;
      end
      wr_valid_i  = 1'b0;
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      wait_idle(200);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
